instr_fetch: RTL

Byte-serial instruction fetcher driving the register/operand unit. Reads code bytes at CS:IP, absorbs segment-override prefixes, collects opcode, ModRM, displacement and immediate into the 48-bit instruction word, and holds it valid until the consumer acknowledges. It produces `instr`, `bitsel`, `direct`, `segment` and `segpref` for the operand/EA unit.

---
 rtl/x86_fetch_pkg.sv | 42 ++++
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch_opcode_len.sv | 43 ++++
 rtl/instr_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/x86_fetch_pkg.sv
// x86_fetch_pkg: shared state, prefix and segment definitions
// for the byte-serial instruction fetcher.
package x86_fetch_pkg;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_MODRM,
        ST_DISP,
        ST_IMM,
        ST_HOLD
    } fetch_state_e;

    localparam logic [7:0] PFX_ES = 8'h26;
    localparam logic [7:0] PFX_CS = 8'h2E;
    localparam logic [7:0] PFX_SS = 8'h36;
    localparam logic [7:0] PFX_DS = 8'h3E;

    localparam logic [1:0] SEG_ES = 2'd0;
    localparam logic [1:0] SEG_CS = 2'd1;
    localparam logic [1:0] SEG_SS = 2'd2;
    localparam logic [1:0] SEG_DS = 2'd3;

    localparam int INSTR_BYTES = 6;

    // Displacement bytes implied by a ModRM byte.
    function automatic logic [1:0] disp_len(input logic [7:0] modrm);
        logic [1:0] md;
        md = modrm[7:6];
        case (md)
            2'b00:   disp_len = (modrm[2:0] == 3'b110) ? 2'd2 : 2'd0;
            2'b01:   disp_len = 2'd1;
            2'b10:   disp_len = 2'd2;
            default: disp_len = 2'd0;
        endcase
    endfunction

    function automatic logic is_seg_prefix(input logic [7:0] b);
        return (b == PFX_ES) || (b == PFX_CS) ||
               (b == PFX_SS) || (b == PFX_DS);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: code-bus and consumer handshake bundle
// between the fetcher (master) and its environment (slave).
interface instr_fetch_if;

    logic [15:0] cs;
    logic [19:0] address;
    logic        rd;
    logic        ready;
    logic [7:0]  in_data;
    logic        jump;
    logic [15:0] jump_ip;
    logic        ack;
    logic        valid;
    logic [47:0] instr;
    logic        bitsel;
    logic        direct;
    logic [1:0]  segment;
    logic        segpref;
    logic [15:0] ip;
    logic [15:0] next_ip;
    logic [2:0]  length;

    modport master (
        input  cs, ready, in_data, jump, jump_ip, ack,
        output address, rd, valid, instr, bitsel, direct,
        output segment, segpref, ip, next_ip, length
    );

    modport slave (
        output cs, ready, in_data, jump, jump_ip, ack,
        input  address, rd, valid, instr, bitsel, direct,
        input  segment, segpref, ip, next_ip, length
    );

endinterface

// File: rtl/instr_fetch_opcode_len.sv
// opcode_len: decodes whether an opcode carries a ModRM byte
// and how many immediate bytes follow it.
module opcode_len (
    input  logic [7:0] opcode,
    input  logic [2:0] modrm_reg,
    output logic       has_modrm,
    output logic [1:0] imm_len
);

    // ModRM presence for the supported opcode groups.
    always_comb begin
        has_modrm = 1'b0;
        casez (opcode)
            8'b00???0??: has_modrm = 1'b1;
            8'b1000????: has_modrm = 1'b1;
            8'b110001??: has_modrm = 1'b1;
            8'b110100??: has_modrm = 1'b1;
            8'hF6, 8'hF7: has_modrm = 1'b1;
            8'hFE, 8'hFF: has_modrm = 1'b1;
            default:     has_modrm = 1'b0;
        endcase
    end

    // Immediate length; F6/F7 only carry one for the TEST (/0) form.
    always_comb begin
        imm_len = 2'd0;
        casez (opcode)
            8'b00???10?: imm_len = 2'd1 + {1'b0, opcode[0]};
            8'b0111????: imm_len = 2'd1;
            8'hEB, 8'hCD: imm_len = 2'd1;
            8'b10110???: imm_len = 2'd1;
            8'b10111???: imm_len = 2'd2;
            8'hE8, 8'hE9: imm_len = 2'd2;
            8'hC2, 8'hCA: imm_len = 2'd2;
            8'h80, 8'h83, 8'hC6: imm_len = 2'd1;
            8'h81, 8'hC7: imm_len = 2'd2;
            8'hF6: imm_len = (modrm_reg == 3'd0) ? 2'd1 : 2'd0;
            8'hF7: imm_len = (modrm_reg == 3'd0) ? 2'd2 : 2'd0;
            default: imm_len = 2'd0;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial x86 fetcher; absorbs segment prefixes and
// assembles opcode/ModRM/disp/imm into a held 48-bit instruction word.
module instr_fetch
    import x86_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [15:0]  fp_q, fp_d;
    logic [15:0]  ip_q, ip_d;
    logic [47:0]  instr_q, instr_d;
    logic         segpref_q, segpref_d;
    logic [1:0]   segment_q, segment_d;
    logic [2:0]   length_q, length_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [1:0]   disp_q, disp_d;
    logic [1:0]   imm_q, imm_d;
    logic         valid_q, valid_d;

    logic         rd;
    logic         xfer;
    logic [7:0]   op_sel;
    logic         has_modrm;
    logic [1:0]   imm_len;
    logic [1:0]   dlen;
    logic [2:0]   len_inc;
    logic [15:0]  next_ip;
    logic [47:0]  instr_put;

    assign rd      = (state_q != ST_HOLD);
    assign xfer    = rd && bus.ready;
    assign op_sel  = (state_q == ST_OPCODE) ? bus.in_data : instr_q[7:0];
    assign dlen    = disp_len(bus.in_data);
    assign len_inc = (length_q == 3'd7) ? 3'd7 : length_q + 3'd1;
    assign next_ip = ip_q + {13'd0, length_q};

    opcode_len u_opcode_len (
        .opcode    (op_sel),
        .modrm_reg (bus.in_data[5:3]),
        .has_modrm (has_modrm),
        .imm_len   (imm_len)
    );

    // Current byte dropped into the instruction word at its stream slot.
    always_comb begin
        instr_put = instr_q;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            if (cnt_q == 3'(k)) begin
                instr_put[8*k +: 8] = bus.in_data;
            end
        end
    end

    // Next-state logic: jump first, then per-state byte handling.
    always_comb begin
        state_d   = state_q;
        fp_d      = fp_q;
        ip_d      = ip_q;
        instr_d   = instr_q;
        segpref_d = segpref_q;
        segment_d = segment_q;
        length_d  = length_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        imm_d     = imm_q;
        valid_d   = valid_q;

        if (bus.jump) begin
            state_d   = ST_OPCODE;
            fp_d      = bus.jump_ip;
            ip_d      = bus.jump_ip;
            instr_d   = '0;
            segpref_d = 1'b0;
            segment_d = SEG_DS;
            length_d  = 3'd0;
            cnt_d     = 3'd0;
            disp_d    = 2'd0;
            imm_d     = 2'd0;
            valid_d   = 1'b0;
        end else begin
            case (state_q)
                ST_OPCODE: begin
                    if (xfer) begin
                        fp_d     = fp_q + 16'd1;
                        length_d = len_inc;
                        if (is_seg_prefix(bus.in_data)) begin
                            segpref_d = 1'b1;
                            segment_d = bus.in_data[4:3];
                        end else begin
                            instr_d[7:0] = bus.in_data;
                            cnt_d        = 3'd1;
                            if (has_modrm) begin
                                state_d = ST_MODRM;
                            end else if (imm_len != 2'd0) begin
                                imm_d   = imm_len;
                                state_d = ST_IMM;
                            end else begin
                                state_d = ST_HOLD;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_MODRM: begin
                    if (xfer) begin
                        fp_d          = fp_q + 16'd1;
                        length_d      = len_inc;
                        instr_d[15:8] = bus.in_data;
                        cnt_d         = 3'd2;
                        disp_d        = dlen;
                        imm_d         = imm_len;
                        if (dlen != 2'd0) begin
                            state_d = ST_DISP;
                        end else if (imm_len != 2'd0) begin
                            state_d = ST_IMM;
                        end else begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_DISP: begin
                    if (xfer) begin
                        fp_d     = fp_q + 16'd1;
                        length_d = len_inc;
                        instr_d  = instr_put;
                        cnt_d    = cnt_q + 3'd1;
                        disp_d   = disp_q - 2'd1;
                        if (disp_q == 2'd1) begin
                            if (imm_q != 2'd0) begin
                                state_d = ST_IMM;
                            end else begin
                                state_d = ST_HOLD;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_IMM: begin
                    if (xfer) begin
                        fp_d     = fp_q + 16'd1;
                        length_d = len_inc;
                        instr_d  = instr_put;
                        cnt_d    = cnt_q + 3'd1;
                        imm_d    = imm_q - 2'd1;
                        if (imm_q == 2'd1) begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.ack) begin
                        state_d   = ST_OPCODE;
                        ip_d      = next_ip;
                        instr_d   = '0;
                        segpref_d = 1'b0;
                        length_d  = 3'd0;
                        cnt_d     = 3'd0;
                        valid_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_OPCODE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_OPCODE;
            fp_q      <= RESET_IP;
            ip_q      <= RESET_IP;
            instr_q   <= '0;
            segpref_q <= 1'b0;
            segment_q <= SEG_DS;
            length_q  <= 3'd0;
            cnt_q     <= 3'd0;
            disp_q    <= 2'd0;
            imm_q     <= 2'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fp_q      <= fp_d;
            ip_q      <= ip_d;
            instr_q   <= instr_d;
            segpref_q <= segpref_d;
            segment_q <= segment_d;
            length_q  <= length_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            imm_q     <= imm_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.address = {bus.cs, 4'h0} + {4'h0, fp_q};
    assign bus.rd      = rd;
    assign bus.valid   = valid_q;
    assign bus.instr   = instr_q;
    assign bus.bitsel  = instr_q[0];
    assign bus.direct  = instr_q[1];
    assign bus.segment = segment_q;
    assign bus.segpref = segpref_q;
    assign bus.ip      = ip_q;
    assign bus.next_ip = next_ip;
    assign bus.length  = length_q;

endmodule
